// File: rtl/issue_scoreboard_pkg.sv
// Shared types and constants for the decode-stage issue scoreboard.
package issue_scoreboard_pkg;

  // Default bubble counts per producer class.
  localparam int SB_ALU_DLY  = 0;
  localparam int SB_LOAD_DLY = 1;
  localparam int SB_CSR_DLY  = 1;

  // Base opcodes used by the decoder.
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  // Producer classes selecting which delay applies to a destination write.
  localparam logic [1:0] DLY_ALU  = 2'd0;
  localparam logic [1:0] DLY_LOAD = 2'd1;
  localparam logic [1:0] DLY_CSR  = 2'd2;

  // R-type view of the instruction in ID (opcode in the low bits).
  typedef struct packed {
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instr_data_t;

  // Register usage of one instruction. Reads/writes of x0 are already
  // masked out, so a set flag always refers to a tracked register.
  typedef struct packed {
    logic       use_rs1;
    logic       use_rs2;
    logic       wr_rd;
    logic [1:0] dly_class;
  } reg_use_t;

endpackage

// File: rtl/issue_scoreboard_reg_use_decoder.sv
// Combinational decode of which architectural registers an instruction reads/writes.
module reg_use_decoder
  import issue_scoreboard_pkg::*;
(
  input  instr_data_t instr_i,
  output reg_use_t    reg_use_o
);

  logic rd_rs1;
  logic rd_rs2;
  logic wr;

  // Opcode class decides source usage, destination write and producer class.
  always_comb begin
    rd_rs1              = 1'b0;
    rd_rs2              = 1'b0;
    wr                  = 1'b0;
    reg_use_o.dly_class = DLY_ALU;
    case (instr_i.opcode)
      OP_LUI, OP_AUIPC, OP_JAL: wr = 1'b1;
      OP_ALU_I, OP_JALR: begin
        rd_rs1 = 1'b1;
        wr     = 1'b1;
      end
      OP_LW: begin
        rd_rs1              = 1'b1;
        wr                  = 1'b1;
        reg_use_o.dly_class = DLY_LOAD;
      end
      OP_CSR: begin
        rd_rs1              = ~instr_i.funct3[2];  // immediate CSR forms have no rs1
        wr                  = 1'b1;
        reg_use_o.dly_class = DLY_CSR;
      end
      OP_ALU: begin
        rd_rs1 = 1'b1;
        rd_rs2 = 1'b1;
        wr     = 1'b1;
      end
      OP_SW, OP_BRANCH: begin
        rd_rs1 = 1'b1;
        rd_rs2 = 1'b1;
      end
      default: ;
    endcase
    reg_use_o.use_rs1 = rd_rs1 & (instr_i.rs1 != 5'd0);
    reg_use_o.use_rs2 = rd_rs2 & (instr_i.rs2 != 5'd0);
    reg_use_o.wr_rd   = wr & (instr_i.rd != 5'd0);
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Decode-stage issue controller: per-register bubble counters and RAW stall decision.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int ALU_DLY  = SB_ALU_DLY,
  parameter int LOAD_DLY = SB_LOAD_DLY,
  parameter int CSR_DLY  = SB_CSR_DLY
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  instr_data_t instr_i,
  input  logic        ex_ready_i,
  input  logic        flush_i,
  output logic        ready_o,
  output logic        issue_valid_o,
  output logic        hazard_o,
  output logic [31:0] stall_cycles_o
);

  localparam int MAX_AL  = (ALU_DLY > LOAD_DLY) ? ALU_DLY : LOAD_DLY;
  localparam int MAX_DLY = (MAX_AL > CSR_DLY) ? MAX_AL : CSR_DLY;
  // Keep at least one bit so an all-zero-delay build still elaborates.
  localparam int CW      = (MAX_DLY > 0) ? $clog2(MAX_DLY + 1) : 1;

  reg_use_t       reg_use;
  logic [CW-1:0]  wr_dly;
  logic [31:0]    busy;
  logic           wr_en;
  logic [31:0]    stall_reg;

  reg_use_decoder u_dec (
    .instr_i   (instr_i),
    .reg_use_o (reg_use)
  );

  // Delay loaded into the destination counter, by producer class.
  always_comb begin
    wr_dly = CW'(ALU_DLY);
    case (reg_use.dly_class)
      DLY_LOAD: wr_dly = CW'(LOAD_DLY);
      DLY_CSR:  wr_dly = CW'(CSR_DLY);
      default:  wr_dly = CW'(ALU_DLY);
    endcase
  end

  // x0 is never tracked.
  assign busy[0] = 1'b0;

  genvar gi;
  for (gi = 1; gi < 32; gi++) begin : g_cnt
    logic [CW-1:0] cnt_reg;

    // Counter per register: a new write overrides the decrement; frozen pipe holds.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_reg <= '0;
      end else if (ex_ready_i) begin
        if (wr_en && (instr_i.rd == 5'(gi))) begin
          cnt_reg <= wr_dly;
        end else if (cnt_reg != '0) begin
          cnt_reg <= cnt_reg - CW'(1);
        end
      end
    end

    assign busy[gi] = |cnt_reg;
  end

  // Hazard uses pre-update counters; self-dependencies therefore never stall.
  assign hazard_o = valid_i & ((reg_use.use_rs1 & busy[instr_i.rs1]) |
                               (reg_use.use_rs2 & busy[instr_i.rs2]));

  assign issue_valid_o = valid_i & ex_ready_i & ~hazard_o & ~flush_i;
  assign ready_o       = ex_ready_i & (~hazard_o | flush_i);
  assign wr_en         = issue_valid_o & reg_use.wr_rd;

  // Saturating count of cycles lost to a real (non-squashed, non-frozen) hazard.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_reg <= '0;
    end else if (valid_i && hazard_o && ex_ready_i && !flush_i && (stall_reg != 32'hFFFF_FFFF)) begin
      stall_reg <= stall_reg + 32'd1;
    end
  end

  assign stall_cycles_o = stall_reg;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench: directed vector table followed by randomized traffic vs. a reference model.
module tb_issue_scoreboard;
  import issue_scoreboard_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  instr_data_t instr_i;
  logic        ex_ready_i;
  logic        flush_i;
  logic        ready_o;
  logic        issue_valid_o;
  logic        hazard_o;
  logic [31:0] stall_cycles_o;

  always #5 clk_i = ~clk_i;

  issue_scoreboard dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .valid_i        (valid_i),
    .instr_i        (instr_i),
    .ex_ready_i     (ex_ready_i),
    .flush_i        (flush_i),
    .ready_o        (ready_o),
    .issue_valid_o  (issue_valid_o),
    .hazard_o       (hazard_o),
    .stall_cycles_o (stall_cycles_o)
  );

  typedef struct {
    logic        rst;
    logic        valid;
    instr_data_t instr;
    logic        exr;
    logic        fl;
    logic        e_ready;
    logic        e_issue;
    logic        e_haz;
    logic [31:0] e_stall;
  } vec_t;

  vec_t vq[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  // Reference model: a register is readable once the number of advancing
  // cycles reaches the value recorded when its latest producer issued.
  int unsigned adv;
  int unsigned ready_adv[32];
  logic [31:0] stall_m;

  function automatic instr_data_t mk(input logic [6:0] op, input int rd, input int f3,
                                     input int rs1, input int rs2);
    instr_data_t t;
    t.opcode = op;
    t.rd     = 5'(rd);
    t.funct3 = 3'(f3);
    t.rs1    = 5'(rs1);
    t.rs2    = 5'(rs2);
    return t;
  endfunction

  function automatic void m_decode(input instr_data_t i, output bit u1, output bit u2,
                                   output bit w, output int d);
    u1 = 0; u2 = 0; w = 0; d = SB_ALU_DLY;
    if (i.opcode == OP_LUI || i.opcode == OP_AUIPC || i.opcode == OP_JAL) w = 1;
    else if (i.opcode == OP_ALU_I || i.opcode == OP_JALR) begin u1 = 1; w = 1; end
    else if (i.opcode == OP_LW) begin u1 = 1; w = 1; d = SB_LOAD_DLY; end
    else if (i.opcode == OP_CSR) begin u1 = (i.funct3[2] == 1'b0); w = 1; d = SB_CSR_DLY; end
    else if (i.opcode == OP_ALU) begin u1 = 1; u2 = 1; w = 1; end
    else if (i.opcode == OP_SW || i.opcode == OP_BRANCH) begin u1 = 1; u2 = 1; end
  endfunction

  function automatic bit reg_pending(input logic [4:0] r);
    return (r != 0) && (ready_adv[r] > adv);
  endfunction

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s @%0d: got %0h, expected %0h", nm, idx, act, exp);
  endtask

  task automatic model_reset();
    adv = 0;
    stall_m = '0;
    for (int r = 0; r < 32; r++) ready_adv[r] = 0;
  endtask

  // One clock cycle: drive, check (table or model), advance model, clock edge.
  task automatic run_cycle(input vec_t v, input bit use_tab, input int idx);
    bit u1, u2, w;
    int d;
    logic m_haz, m_issue, m_ready;
    rst_i      = v.rst;
    valid_i    = v.valid;
    instr_i    = v.instr;
    ex_ready_i = v.exr;
    flush_i    = v.fl;
    #3;
    m_decode(v.instr, u1, u2, w, d);
    m_haz   = v.valid & ((u1 & reg_pending(v.instr.rs1)) | (u2 & reg_pending(v.instr.rs2)));
    m_issue = v.valid & v.exr & ~m_haz & ~v.fl;
    m_ready = v.exr & (~m_haz | v.fl);
    if (use_tab) begin
      check("tab_ready", idx, 32'(ready_o), 32'(v.e_ready));
      check("tab_issue", idx, 32'(issue_valid_o), 32'(v.e_issue));
      check("tab_hazard", idx, 32'(hazard_o), 32'(v.e_haz));
      check("tab_stall", idx, stall_cycles_o, v.e_stall);
    end else begin
      check("rnd_ready", idx, 32'(ready_o), 32'(m_ready));
      check("rnd_issue", idx, 32'(issue_valid_o), 32'(m_issue));
      check("rnd_hazard", idx, 32'(hazard_o), 32'(m_haz));
      check("rnd_stall", idx, stall_cycles_o, stall_m);
    end
    if (v.rst) begin
      model_reset();
    end else if (v.exr) begin
      if (m_haz && v.valid && !v.fl && stall_m != 32'hFFFF_FFFF) stall_m = stall_m + 1;
      if (m_issue && w && v.instr.rd != 0) ready_adv[v.instr.rd] = adv + 1 + d;
      adv++;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic row(input logic r, input logic v, input instr_data_t i, input logic e,
                     input logic f, input logic er, input logic ei, input logic eh,
                     input int es);
    vec_t t;
    t.rst = r; t.valid = v; t.instr = i; t.exr = e; t.fl = f;
    t.e_ready = er; t.e_issue = ei; t.e_haz = eh; t.e_stall = 32'(es);
    vq.push_back(t);
  endtask

  initial begin
    instr_data_t nop, lw5, lw0, lw7, add6_5, addi5, add655, add6_0, sw5, add4_3;
    instr_data_t add8_7, addi5_5, csrrw9, csrrsi10, add10_9;
    logic [6:0] ops[11];
    vec_t rv;

    nop      = mk(OP_ALU, 0, 0, 0, 0);
    lw5      = mk(OP_LW, 5, 2, 1, 0);
    lw0      = mk(OP_LW, 0, 2, 1, 0);
    lw7      = mk(OP_LW, 7, 2, 1, 0);
    add6_5   = mk(OP_ALU, 6, 0, 5, 2);
    addi5    = mk(OP_ALU_I, 5, 0, 0, 0);
    add655   = mk(OP_ALU, 6, 0, 5, 5);
    add6_0   = mk(OP_ALU, 6, 0, 0, 2);
    sw5      = mk(OP_SW, 3, 2, 1, 5);
    add4_3   = mk(OP_ALU, 4, 0, 3, 0);
    add8_7   = mk(OP_ALU, 8, 0, 7, 0);
    addi5_5  = mk(OP_ALU_I, 5, 0, 5, 0);
    csrrw9   = mk(OP_CSR, 9, 1, 1, 0);
    csrrsi10 = mk(OP_CSR, 10, 6, 9, 0);
    add10_9  = mk(OP_ALU, 10, 0, 9, 0);

    // reset state, ready follows ex_ready
    row(1, 0, nop, 0, 0, 0, 0, 0, 0);
    // load-use: one bubble
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 1, add6_5, 1, 0, 0, 0, 1, 0);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 1);
    row(1, 0, nop, 1, 0, 1, 0, 0, 1);
    // ALU back-to-back: no bubble
    row(0, 1, addi5, 1, 0, 1, 1, 0, 0);
    row(0, 1, add655, 1, 0, 1, 1, 0, 0);
    // x0 untracked; store after load stalls; store rd field is not a write
    row(0, 1, lw0, 1, 0, 1, 1, 0, 0);
    row(0, 1, add6_0, 1, 0, 1, 1, 0, 0);
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 1, sw5, 1, 0, 0, 0, 1, 0);
    row(0, 1, sw5, 1, 0, 1, 1, 0, 1);
    row(0, 1, add4_3, 1, 0, 1, 1, 0, 1);
    row(1, 0, nop, 1, 0, 1, 0, 0, 1);
    // backend freeze during a load-use stall
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 1, add6_5, 0, 0, 0, 0, 1, 0);
    row(0, 1, add6_5, 0, 0, 0, 0, 1, 0);
    row(0, 1, add6_5, 0, 0, 0, 0, 1, 0);
    row(0, 1, add6_5, 1, 0, 0, 0, 1, 0);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 1);
    row(1, 0, nop, 1, 0, 1, 0, 0, 1);
    // flush over a stalled consumer; flushed load writes nothing
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 1, add6_5, 1, 1, 1, 0, 1, 0);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 0);
    row(0, 1, lw7, 1, 1, 1, 0, 0, 0);
    row(0, 1, add8_7, 1, 0, 1, 1, 0, 0);
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 0, add6_5, 1, 0, 1, 0, 0, 0);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 0);
    // reset clears a pending load; WAW younger ALU write wins
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(1, 0, nop, 1, 0, 1, 0, 0, 0);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 0);
    row(0, 1, lw5, 1, 0, 1, 1, 0, 0);
    row(0, 1, addi5_5, 1, 0, 0, 0, 1, 0);
    row(0, 1, addi5_5, 1, 0, 1, 1, 0, 1);
    row(0, 1, add6_5, 1, 0, 1, 1, 0, 1);
    row(1, 0, nop, 1, 0, 1, 0, 0, 1);
    // CSR-use stalls; immediate CSR form has no rs1
    row(0, 1, csrrw9, 1, 0, 1, 1, 0, 0);
    row(0, 1, csrrsi10, 1, 0, 1, 1, 0, 0);
    row(0, 1, csrrw9, 1, 0, 1, 1, 0, 0);
    row(0, 1, add10_9, 1, 0, 0, 0, 1, 0);
    row(0, 1, add10_9, 1, 0, 1, 1, 0, 1);

    rst_i = 1'b1; valid_i = 1'b0; instr_i = nop; ex_ready_i = 1'b1; flush_i = 1'b0;
    model_reset();
    @(posedge clk_i);
    @(posedge clk_i);
    #1;

    foreach (vq[k]) run_cycle(vq[k], 1'b1, k);

    // randomized traffic against the reference model
    ops = '{OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LW, OP_SW,
            OP_ALU_I, OP_ALU, OP_CSR, 7'b1111111};
    rv.rst = 1; rv.valid = 0; rv.instr = nop; rv.exr = 1; rv.fl = 0;
    rv.e_ready = 0; rv.e_issue = 0; rv.e_haz = 0; rv.e_stall = 0;
    run_cycle(rv, 1'b0, 0);
    for (int n = 1; n <= 1500; n++) begin
      rv.rst   = ($urandom_range(0, 99) < 2);
      rv.valid = ($urandom_range(0, 9) < 8);
      rv.exr   = ($urandom_range(0, 9) < 8);
      rv.fl    = ($urandom_range(0, 9) < 1);
      rv.instr = mk(ops[$urandom_range(0, 10)], $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 7), $urandom_range(0, 7));
      run_cycle(rv, 1'b0, n);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
